// File: rtl/lreport_gen.sv
// Beacon-report generator/merger on the 134-bit UM packet bus: forwards upstream packets
// (DMID rewritten) and inserts a report packet at a packet boundary after each time tick.
module lreport_gen #(
  parameter int                N_STAT_WORDS = 15,
  parameter int                PERIOD_BIT   = 21,
  parameter logic [PERIOD_BIT:0] TICK_VAL   = 'hff,
  parameter logic [47:0]       CNC_MAC      = 48'h010203040506,
  parameter logic [15:0]       ETH_TYPE     = 16'h88f7,
  parameter logic [7:0]        RPT_SMID     = 8'd128,
  parameter logic [7:0]        FWD_DMID     = 8'd1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_data_wr,
  input  logic [133:0]              in_data,
  input  logic                      in_valid_wr,
  input  logic                      in_valid,
  output logic                      pktin_ready,
  output logic                      out_data_wr,
  output logic [133:0]              out_data,
  output logic                      out_valid_wr,
  output logic                      out_valid,
  input  logic [47:0]               precision_time,
  input  logic [47:0]               local_mac,
  output logic [47:0]               out_local_mac,
  input  logic                      report_en,
  input  logic                      update_req,
  input  logic [128*N_STAT_WORDS-1:0] stat_words,
  output logic                      report_busy,
  output logic [15:0]               report_seq,
  output logic [15:0]               miss_cnt,
  output logic [15:0]               proto_err_cnt
);

  localparam int               IDX_W    = $clog2(N_STAT_WORDS + 6);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAT_WORDS + 5);
  localparam logic [15:0]      PKT_LEN  = 16'((N_STAT_WORDS + 6) * 16);
  localparam logic [15:0]      PTP_LEN  = 16'((N_STAT_WORDS + 4) * 16);

  typedef enum logic [1:0] {IDLE, PASS, GAP, REPORT} state_t;

  state_t           state, state_next;
  logic             pending;
  logic [47:0]      pend_ts;
  logic [47:0]      rpt_ts;
  logic [IDX_W-1:0] idx;
  logic             update_ack;
  logic             tick;
  logic             in_head;
  logic             in_tail;
  logic [3:0]       rpt_type;
  logic [127:0]     stat_cur;
  logic [133:0]     rpt_word;
  logic [133:0]     fwd_word;

  assign out_local_mac = local_mac;
  assign tick     = report_en && (precision_time[PERIOD_BIT:0] == TICK_VAL);
  assign in_head  = in_data_wr && (in_data[133:132] == 2'b01);
  assign in_tail  = in_data_wr && (in_data[133:132] == 2'b10);
  assign rpt_type = (update_req != update_ack) ? 4'he : 4'hf;
  assign fwd_word = (in_data[133:132] == 2'b01) ? {in_data[133:88], FWD_DMID, in_data[79:0]} : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_head) state_next = PASS;
               else if (pending) state_next = GAP;
      PASS:    if (in_tail) state_next = IDLE;
      GAP:     state_next = REPORT;
      REPORT:  if (idx == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Report word for the current index; statistics are read live, not latched.
  always_comb begin
    stat_cur = '0;
    for (int k = 0; k < N_STAT_WORDS; k++) begin
      if (idx == IDX_W'(k + 6)) stat_cur = stat_words[128*(N_STAT_WORDS-k)-1 -: 128];
    end
    if (idx == IDX_W'(0))      rpt_word = {2'b01, 4'b0, 1'b1, 1'b0, 14'b0, PKT_LEN, RPT_SMID, 8'd1, 32'b0, rpt_ts};
    else if (idx == IDX_W'(1)) rpt_word = {2'b11, 4'b0, 128'b0};
    else if (idx == IDX_W'(2)) rpt_word = {2'b11, 4'b0, CNC_MAC, local_mac, ETH_TYPE, 4'b0, rpt_type, 8'b0};
    else if (idx == IDX_W'(3)) rpt_word = {2'b11, 4'b0, PTP_LEN, 112'b0};
    else if (idx == IDX_W'(4)) rpt_word = {2'b11, 4'b0, 96'b0, report_seq, 16'b0};
    else if (idx == IDX_W'(5)) rpt_word = {2'b11, 4'b0, 32'b0, rpt_ts, 48'b0};
    else                       rpt_word = {2'b11, 4'b0, stat_cur};
    if (idx == LAST_IDX) rpt_word[133:132] = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= 1'b0;
      pend_ts       <= '0;
      rpt_ts        <= '0;
      idx           <= '0;
      update_ack    <= 1'b0;
      pktin_ready   <= 1'b1;
      out_data_wr   <= 1'b0;
      out_data      <= '0;
      out_valid_wr  <= 1'b0;
      out_valid     <= 1'b0;
      report_busy   <= 1'b0;
      report_seq    <= '0;
      miss_cnt      <= '0;
      proto_err_cnt <= '0;
    end else begin
      if (tick) pend_ts <= precision_time;
      if (tick && pending && miss_cnt != 16'hffff) miss_cnt <= miss_cnt + 16'd1;
      // A tick landing in the GAP cycle keeps the request alive for the next report.
      if (state == GAP) pending <= tick;
      else if (tick)    pending <= 1'b1;
      if ((state == GAP || state == REPORT) && in_data_wr && proto_err_cnt != 16'hffff)
        proto_err_cnt <= proto_err_cnt + 16'd1;

      out_data_wr  <= 1'b0;
      out_data     <= '0;
      out_valid_wr <= 1'b0;
      out_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (in_head) begin
            out_data_wr  <= 1'b1;
            out_data     <= fwd_word;
            out_valid_wr <= in_valid_wr;
            out_valid    <= in_valid;
          end else if (pending) begin
            pktin_ready <= 1'b0;
            report_busy <= 1'b1;
          end
        end
        PASS: begin
          out_data_wr  <= in_data_wr;
          out_data     <= in_data_wr ? fwd_word : '0;
          out_valid_wr <= in_valid_wr;
          out_valid    <= in_valid;
        end
        GAP: begin
          rpt_ts <= pend_ts;
          idx    <= '0;
        end
        REPORT: begin
          out_data_wr <= 1'b1;
          out_data    <= rpt_word;
          idx         <= idx + 1'b1;
          if (idx == IDX_W'(2)) update_ack <= update_req;
          if (idx == LAST_IDX) begin
            out_valid_wr <= 1'b1;
            out_valid    <= 1'b1;
            report_seq   <= report_seq + 16'd1;
            pktin_ready  <= 1'b1;
            report_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lreport_gen.sv
// Scoreboard bench for lreport_gen: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_lreport_gen;

  localparam int          N         = 15;
  localparam logic [47:0] LOCAL_MAC = 48'haabb_ccdd_eeff;

  typedef struct packed {
    logic [133:0] d;
    logic         vwr;
    logic         v;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_data_wr = 1'b0;
  logic [133:0]   in_data = '0;
  logic           in_valid_wr = 1'b0;
  logic           in_valid = 1'b0;
  logic           pktin_ready;
  logic           out_data_wr;
  logic [133:0]   out_data;
  logic           out_valid_wr;
  logic           out_valid;
  logic [47:0]    precision_time = '0;
  logic [47:0]    local_mac = LOCAL_MAC;
  logic [47:0]    out_local_mac;
  logic           report_en = 1'b1;
  logic           update_req = 1'b0;
  logic [128*N-1:0] stat_words;
  logic           report_busy;
  logic [15:0]    report_seq;
  logic [15:0]    miss_cnt;
  logic [15:0]    proto_err_cnt;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  lreport_gen dut (
    .clk(clk), .rst_n(rst_n),
    .in_data_wr(in_data_wr), .in_data(in_data), .in_valid_wr(in_valid_wr), .in_valid(in_valid),
    .pktin_ready(pktin_ready),
    .out_data_wr(out_data_wr), .out_data(out_data), .out_valid_wr(out_valid_wr), .out_valid(out_valid),
    .precision_time(precision_time), .local_mac(local_mac), .out_local_mac(out_local_mac),
    .report_en(report_en), .update_req(update_req), .stat_words(stat_words),
    .report_busy(report_busy), .report_seq(report_seq), .miss_cnt(miss_cnt), .proto_err_cnt(proto_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] stat_val(input int k);
    return {4{32'h5000_0000 | 32'(k)}};
  endfunction

  function automatic logic [133:0] mk_word(input logic [1:0] tag, input logic [31:0] seed);
    return {tag, 4'b0, {4{seed}}};
  endfunction

  task automatic checkOutput(input string name, input logic [133:0] act, input logic [133:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every output word is matched against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_data_wr) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_word: got %h expected no output", out_data);
      end else begin
        e = sb.pop_front();
        checkOutput("out_data", out_data, e.d);
        checkOutput("out_valid_wr", 134'(out_valid_wr), 134'(e.vwr));
        checkOutput("out_valid", 134'(out_valid), 134'(e.v));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Drive one input word for one cycle; optionally queue its forwarded image.
  task automatic applyStimulus(input logic [133:0] w, input logic vwr, input logic fwd);
    exp_t e;
    in_data_wr  = 1'b1;
    in_data     = w;
    in_valid_wr = vwr;
    in_valid    = vwr;
    if (fwd) begin
      e.d = w;
      if (w[133:132] == 2'b01) e.d[87:80] = 8'h01;
      e.vwr = vwr;
      e.v   = vwr;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_data_wr  = 1'b0;
    in_data     = '0;
    in_valid_wr = 1'b0;
    in_valid    = 1'b0;
  endtask

  task automatic do_tick(input logic [47:0] ts, input logic en);
    precision_time = ts;
    report_en      = en;
    @(posedge clk); #1;
    precision_time = '0;
    report_en      = 1'b1;
  endtask

  task automatic push_report(input logic [47:0] ts, input logic [15:0] seq, input logic [3:0] typ, input int nwords);
    exp_t e;
    for (int i = 0; i < nwords; i++) begin
      case (i)
        0: e.d = {2'b01, 4'b0, 1'b1, 1'b0, 14'b0, 16'd336, 8'd128, 8'd1, 32'b0, ts};
        1: e.d = {2'b11, 4'b0, 128'b0};
        2: e.d = {2'b11, 4'b0, 48'h010203040506, LOCAL_MAC, 16'h88f7, 4'b0, typ, 8'b0};
        3: e.d = {2'b11, 4'b0, 16'd304, 112'b0};
        4: e.d = {2'b11, 4'b0, 96'b0, seq, 16'b0};
        5: e.d = {2'b11, 4'b0, 32'b0, ts, 48'b0};
        default: e.d = {((i == 20) ? 2'b10 : 2'b11), 4'b0, stat_val(i - 6)};
      endcase
      e.vwr = (i == 20);
      e.v   = (i == 20);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_drain: got %0d words outstanding expected 0", name, sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    for (int k = 0; k < N; k++) stat_words[128*(N-k)-1 -: 128] = stat_val(k);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 134'(pktin_ready), 134'(1));
    checkOutput("rst_data_wr", 134'(out_data_wr), 134'(0));
    checkOutput("rst_data", out_data, 134'(0));
    checkOutput("rst_busy", 134'(report_busy), 134'(0));
    checkOutput("rst_seq", 134'(report_seq), 134'(0));
    checkOutput("rst_miss", 134'(miss_cnt), 134'(0));
    checkOutput("rst_proto", 134'(proto_err_cnt), 134'(0));
    checkOutput("local_mac", 134'(out_local_mac), 134'(LOCAL_MAC));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain forwarding with DMID rewrite.
    applyStimulus(mk_word(2'b01, 32'hdead_beef), 1'b0, 1'b1);
    applyStimulus(mk_word(2'b11, 32'h1111_2222), 1'b0, 1'b1);
    applyStimulus(mk_word(2'b10, 32'h3333_4444), 1'b1, 1'b1);
    checkOutput("t1_ready", 134'(pktin_ready), 134'(1));
    wait_drain("t1");

    // Tick at idle: ready drops, full report with seq 0.
    do_tick(48'h1234_0000_00ff, 1'b1);
    push_report(48'h1234_0000_00ff, 16'd0, 4'hf, 21);
    @(posedge clk); #1;
    checkOutput("t2_ready_low", 134'(pktin_ready), 134'(0));
    checkOutput("t2_busy", 134'(report_busy), 134'(1));
    wait_drain("t2");
    checkOutput("t2_seq", 134'(report_seq), 134'(1));
    checkOutput("t2_ready_high", 134'(pktin_ready), 134'(1));
    checkOutput("t2_busy_clear", 134'(report_busy), 134'(0));

    // Tick on word 2 of a 5-word packet; word0 lands 3 edges after the tail.
    pop_cyc.delete();
    applyStimulus(mk_word(2'b01, 32'h0a0a_0a0a), 1'b0, 1'b1);
    precision_time = 48'h3333_0000_00ff;
    applyStimulus(mk_word(2'b11, 32'h0b0b_0b0b), 1'b0, 1'b1);
    precision_time = '0;
    applyStimulus(mk_word(2'b11, 32'h0c0c_0c0c), 1'b0, 1'b1);
    applyStimulus(mk_word(2'b11, 32'h0d0d_0d0d), 1'b0, 1'b1);
    applyStimulus(mk_word(2'b10, 32'h0e0e_0e0e), 1'b1, 1'b1);
    push_report(48'h3333_0000_00ff, 16'd1, 4'hf, 21);
    wait_drain("t3");
    tests_run++;
    if (pop_cyc.size() < 6 || (pop_cyc[5] - pop_cyc[4]) != 3) begin
      tests_failed++;
      $display("[TB] FAIL t3_report_gap: got %0d words / delta %0d expected delta 3",
               pop_cyc.size(), (pop_cyc.size() >= 6) ? pop_cyc[5] - pop_cyc[4] : -1);
    end

    // Two ticks while a long packet holds the bus: one miss, second timestamp wins.
    applyStimulus(mk_word(2'b01, 32'h1357_9bdf), 1'b0, 1'b1);
    @(posedge clk); #1;
    do_tick(48'haaaa_5500_00ff, 1'b1);
    @(posedge clk); #1;
    do_tick(48'hbbbb_cc00_00ff, 1'b1);
    checkOutput("t4_miss", 134'(miss_cnt), 134'(1));
    applyStimulus(mk_word(2'b11, 32'h2468_ace0), 1'b0, 1'b1);
    applyStimulus(mk_word(2'b10, 32'hfedc_ba98), 1'b1, 1'b1);
    push_report(48'hbbbb_cc00_00ff, 16'd2, 4'hf, 21);
    wait_drain("t4");
    do_tick(48'h0000_0000_00ff, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t4_disabled_seq", 134'(report_seq), 134'(3));
    checkOutput("t4_disabled_busy", 134'(report_busy), 134'(0));

    // Update request toggled, plus a stray word during the report.
    update_req = 1'b1;
    do_tick(48'h0c0c_0c40_00ff, 1'b1);
    push_report(48'h0c0c_0c40_00ff, 16'd3, 4'he, 21);
    n = 0;
    while (!report_busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(mk_word(2'b11, 32'h7777_7777), 1'b0, 1'b0);
    wait_drain("t5a");
    checkOutput("t5_proto", 134'(proto_err_cnt), 134'(1));
    do_tick(48'h0d0d_0000_00ff, 1'b1);
    push_report(48'h0d0d_0000_00ff, 16'd4, 4'hf, 21);
    wait_drain("t5b");
    checkOutput("t5_seq", 134'(report_seq), 134'(5));

    // Reset while word 10 of a report is due.
    do_tick(48'h0e0e_0000_00ff, 1'b1);
    push_report(48'h0e0e_0000_00ff, 16'd5, 4'hf, 10);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("t6_partial", 134'(sb.size()), 134'(0));
    sb.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("t6_data_wr", 134'(out_data_wr), 134'(0));
    checkOutput("t6_data", out_data, 134'(0));
    checkOutput("t6_ready", 134'(pktin_ready), 134'(1));
    checkOutput("t6_busy", 134'(report_busy), 134'(0));
    checkOutput("t6_seq", 134'(report_seq), 134'(0));
    checkOutput("t6_miss", 134'(miss_cnt), 134'(0));
    checkOutput("t6_proto", 134'(proto_err_cnt), 134'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Acknowledge was cleared by reset while update_req is still 1, so type e.
    do_tick(48'h0f0f_0000_00ff, 1'b1);
    push_report(48'h0f0f_0000_00ff, 16'd0, 4'he, 21);
    wait_drain("t6");
    checkOutput("t6_seq_after", 134'(report_seq), 134'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
